// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: fabric SPI mode-0 slave. Deframes fixed-length host frames
// into command and data words and returns core results through a TX FIFO.
// Ports:
//   clk, rst_n              system clock, synchronous active-low reset
//   spi_sck/ss/mosi         raw SPI pins (ss active low)
//   spi_miso                registered slave output
//   spi_cmd(_valid)         last command byte, 1-clk update pulse
//   spi_data_out(_valid)    last data word, 1-clk update pulse
//   spi_data_in(_valid)     word pushed into the TX FIFO
//   spi_data_in_ready       TX FIFO not full
module spi_slave_fifo #(
    parameter int DATA_BYTES  = 1,
    parameter int FRAME_BYTES = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    spi_sck,
    input  logic                    spi_ss,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic [7:0]              spi_cmd,
    output logic                    spi_cmd_valid,
    output logic [8*DATA_BYTES-1:0] spi_data_out,
    output logic                    spi_data_out_valid,
    input  logic [8*DATA_BYTES-1:0] spi_data_in,
    input  logic                    spi_data_in_valid,
    output logic                    spi_data_in_ready
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FRAME_BYTES);
    localparam logic [7:0] OP_INIT = 8'h01;
    localparam logic [7:0] OP_READ = 8'h02;
    localparam logic [7:0] OP_CMD  = 8'h03;
    localparam logic [7:0] OP_DATA = 8'h04;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);

    logic [1:0]    sck_sync_q, ss_sync_q, mosi_sync_q;
    logic          sck_prev_q, ss_prev_q;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [7:0]    rx_q, rx_d, op_q, op_d, tx_q, tx_d;
    logic [W-1:0]  acc_q, acc_d, rd_q, rd_d;
    logic          miso_q, miso_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          cmd_vld_q, cmd_vld_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          init_q, init_d, udf_q, udf_d;
    logic          ovf_q, ovf_d, rdy_q, rdy_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [FIFO_DEPTH];

    logic          sck_rise, sck_fall, ss_act, ss_fall;
    logic          byte_done, push, pop, flush, full, empty;
    logic [7:0]    rx_byte, status;
    logic [W-1:0]  word;
    int            bidx;

    assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
    assign ss_act    = ~ss_sync_q[1];
    assign ss_fall   = ss_act & ss_prev_q;
    assign byte_done = ss_act & sck_rise & (bit_q == 3'd7);
    assign full      = cnt_q == FULL_CNT;
    assign empty     = cnt_q == '0;
    assign push      = spi_data_in_valid & rdy_q;
    assign rx_byte   = LSB_FIRST ? {mosi_sync_q[1], rx_q[7:1]}
                                 : {rx_q[6:0], mosi_sync_q[1]};
    // Host sees all-zero traffic until the first INIT.
    assign status    = init_q ? {4'b0100, ovf_q, udf_q, full, ~empty}
                              : 8'h00;

    always_comb begin
        bit_d      = bit_q;
        byte_d     = byte_q;
        rx_d       = rx_q;
        op_d       = op_q;
        tx_d       = tx_q;
        acc_d      = acc_q;
        rd_d       = rd_q;
        miso_d     = miso_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = 1'b0;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        init_d     = init_q;
        udf_d      = udf_q;
        ovf_d      = ovf_q;
        pop        = 1'b0;
        flush      = 1'b0;
        word       = '0;
        bidx       = int'(byte_q);

        if (!ss_act) begin
            bit_d  = '0;
            byte_d = '0;
        end else if (sck_rise) begin
            rx_d  = rx_byte;
            bit_d = bit_q + 3'd1;
        end

        if (byte_done) begin
            byte_d = (byte_q == LAST_BYTE) ? '0 : byte_q + 1'b1;
            if (byte_q == '0) begin
                op_d = rx_byte;
                if (rx_byte == OP_INIT) begin
                    init_d = 1'b1;
                    flush  = 1'b1;
                end else if (init_q && rx_byte == OP_READ) begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        word = mem_q[rptr_q];
                    end
                end
                // rd_q drains to zero, which also yields the padding bytes.
                tx_d = word[7:0];
                rd_d = word >> 8;
            end else begin
                if (init_q && op_q == OP_CMD && bidx == 1) begin
                    cmd_d     = rx_byte;
                    cmd_vld_d = 1'b1;
                end
                if (bidx <= DATA_BYTES) begin
                    acc_d[8*(bidx-1) +: 8] = rx_byte;
                    if (init_q && op_q == OP_DATA && bidx == DATA_BYTES) begin
                        dout_d     = acc_d;
                        dout_vld_d = 1'b1;
                    end
                end
                if (byte_q == LAST_BYTE) begin
                    tx_d = status;
                end else begin
                    tx_d = rd_q[7:0];
                    rd_d = rd_q >> 8;
                end
            end
        end

        if (ss_fall) begin
            tx_d   = status;
            miso_d = LSB_FIRST ? status[0] : status[7];
        end else if (ss_act && sck_fall) begin
            // bit_q already points at the next bit after the rise.
            miso_d = LSB_FIRST ? tx_q[bit_q] : tx_q[3'd7 - bit_q];
        end

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            udf_d  = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (spi_data_in_valid && !rdy_q) ovf_d = 1'b1;
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
        rdy_d = cnt_d != FULL_CNT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= 2'b00;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
            bit_q       <= '0;
            byte_q      <= '0;
            rx_q        <= '0;
            op_q        <= '0;
            tx_q        <= '0;
            acc_q       <= '0;
            rd_q        <= '0;
            miso_q      <= 1'b0;
            cmd_q       <= '0;
            cmd_vld_q   <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            init_q      <= 1'b0;
            udf_q       <= 1'b0;
            ovf_q       <= 1'b0;
            rdy_q       <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            ss_sync_q   <= {ss_sync_q[0], spi_ss};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            rx_q        <= rx_d;
            op_q        <= op_d;
            tx_q        <= tx_d;
            acc_q       <= acc_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            init_q      <= init_d;
            udf_q       <= udf_d;
            ovf_q       <= ovf_d;
            rdy_q       <= rdy_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) mem_q[wptr_q] <= spi_data_in;
    end

    assign spi_miso           = miso_q;
    assign spi_cmd            = cmd_q;
    assign spi_cmd_valid      = cmd_vld_q;
    assign spi_data_out       = dout_q;
    assign spi_data_out_valid = dout_vld_q;
    assign spi_data_in_ready  = rdy_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: randomized scoreboard bench for spi_slave_fifo
// (2-byte words, 4-byte frames, 4-entry FIFO, LSB first).
module tb_spi_slave_fifo;
    localparam int DB    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  spi_cmd;
    logic        spi_cmd_valid;
    logic [15:0] spi_data_out;
    logic        spi_data_out_valid;
    logic [15:0] spi_data_in = '0;
    logic        spi_data_in_valid = 1'b0;
    logic        spi_data_in_ready;

    spi_slave_fifo #(
        .DATA_BYTES (DB),
        .FRAME_BYTES(4),
        .FIFO_DEPTH (DEPTH),
        .LSB_FIRST  (1'b1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .spi_sck           (spi_sck),
        .spi_ss            (spi_ss),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso),
        .spi_cmd           (spi_cmd),
        .spi_cmd_valid     (spi_cmd_valid),
        .spi_data_out      (spi_data_out),
        .spi_data_out_valid(spi_data_out_valid),
        .spi_data_in       (spi_data_in),
        .spi_data_in_valid (spi_data_in_valid),
        .spi_data_in_ready (spi_data_in_ready)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  exp_miso[$];
    logic [7:0]  got_miso[$];
    logic [7:0]  exp_cmd[$];
    logic [15:0] exp_dat[$];
    logic [15:0] fq[$];
    bit          init_m, udf_m, ovf_m;
    logic [7:0]  txb [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: one frame's effect, given how many bits were clocked.
    task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int nbits);
        logic [7:0]  st;
        logic [15:0] w;
        st = 8'h00;
        if (init_m) begin
            st = 8'h40;
            if (fq.size() > 0)      st[0] = 1'b1;
            if (fq.size() == DEPTH) st[1] = 1'b1;
            st[2] = udf_m;
            st[3] = ovf_m;
        end
        w = 16'h0000;
        if (nbits >= 8) begin
            exp_miso.push_back(st);
            if (b0 == 8'h01) begin
                init_m = 1'b1;
                fq.delete();
                udf_m = 1'b0;
                ovf_m = 1'b0;
            end else if (init_m && b0 == 8'h02) begin
                if (fq.size() == 0) udf_m = 1'b1;
                else w = fq.pop_front();
            end
        end
        if (nbits >= 16) exp_miso.push_back(w[7:0]);
        if (nbits >= 24) exp_miso.push_back(w[15:8]);
        if (nbits >= 32) exp_miso.push_back(8'h00);
        if (init_m && b0 == 8'h03 && nbits >= 16) exp_cmd.push_back(b1);
        if (init_m && b0 == 8'h04 && nbits >= 24) exp_dat.push_back({b2, b1});
    endtask

    task automatic set_fr(input int f, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d);
        txb[4*f]   = a;
        txb[4*f+1] = b;
        txb[4*f+2] = c;
        txb[4*f+3] = d;
    endtask

    task automatic send(input int nfr, input int nbits_last);
        logic [7:0] rb;
        int total;
        rb = 8'h00;
        for (int f = 0; f < nfr; f++)
            model_frame(txb[4*f], txb[4*f+1], txb[4*f+2],
                        (f == nfr - 1) ? nbits_last : 32);
        total = (nfr - 1) * 32 + nbits_last;
        @(negedge clk);
        spi_ss = 1'b0;
        #100;
        for (int i = 0; i < total; i++) begin
            spi_mosi = txb[i/8][i%8];
            #50 spi_sck = 1'b1;
            rb[i%8] = spi_miso;
            if (i % 8 == 7) got_miso.push_back(rb);
            #50 spi_sck = 1'b0;
        end
        #50 spi_ss = 1'b1;
        #200;
    endtask

    task automatic push_w(input logic [15:0] w);
        @(negedge clk);
        chk("ready", {31'b0, spi_data_in_ready}, {31'b0, fq.size() < DEPTH});
        spi_data_in       = w;
        spi_data_in_valid = 1'b1;
        if (fq.size() < DEPTH) fq.push_back(w);
        else ovf_m = 1'b1;
        @(negedge clk);
        spi_data_in_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, {31'b0, spi_miso}, 0);
        chk({tag, "_cmd"}, {24'b0, spi_cmd}, 0);
        chk({tag, "_cmd_valid"}, {31'b0, spi_cmd_valid}, 0);
        chk({tag, "_data_out"}, {16'b0, spi_data_out}, 0);
        chk({tag, "_data_valid"}, {31'b0, spi_data_out_valid}, 0);
        chk({tag, "_ready"}, {31'b0, spi_data_in_ready}, 1);
    endtask

    always @(negedge clk) begin
        if (spi_cmd_valid) begin
            if (exp_cmd.size() == 0)
                chk("cmd_valid_unexpected", {31'b0, spi_cmd_valid}, 0);
            else
                chk("cmd", {24'b0, spi_cmd}, {24'b0, exp_cmd.pop_front()});
        end
        if (spi_data_out_valid) begin
            if (exp_dat.size() == 0)
                chk("data_valid_unexpected", {31'b0, spi_data_out_valid}, 0);
            else
                chk("data_out", {16'b0, spi_data_out},
                    {16'b0, exp_dat.pop_front()});
        end
        while (got_miso.size() > 0) begin
            if (exp_miso.size() == 0) begin
                chk("miso_unexpected", {24'b0, got_miso.pop_front()}, 32'hFFFF);
            end else begin
                chk("miso", {24'b0, got_miso.pop_front()},
                    {24'b0, exp_miso.pop_front()});
            end
        end
    end

    initial begin
        int r;
        init_m = 1'b0;
        udf_m  = 1'b0;
        ovf_m  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst");

        set_fr(0, 8'h03, 8'h55, 8'h00, 8'h00);
        send(1, 32);
        set_fr(0, 8'h01, 8'h00, 8'h00, 8'h00);
        send(1, 32);
        set_fr(0, 8'h03, 8'hA7, 8'h00, 8'h00);
        send(1, 32);

        push_w(16'hBEEF);
        set_fr(0, 8'h02, 8'h00, 8'h00, 8'h00);
        send(1, 32);
        chk("ready_after_read", {31'b0, spi_data_in_ready}, 1);

        for (int i = 0; i < 5; i++) push_w(16'(i + 1) * 16'h1111);
        set_fr(0, 8'h00, 8'h00, 8'h00, 8'h00);
        send(1, 32);
        set_fr(0, 8'h02, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) send(1, 32);
        set_fr(0, 8'h00, 8'h00, 8'h00, 8'h00);
        send(1, 32);

        set_fr(0, 8'h04, 8'h3C, 8'h00, 8'h00);
        send(1, 12);
        send(1, 32);

        set_fr(0, 8'h03, 8'($urandom), 8'($urandom), 8'($urandom));
        set_fr(1, 8'h04, 8'($urandom), 8'($urandom), 8'($urandom));
        send(2, 32);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                        push_w(16'($urandom));
                end
                2, 3: begin
                    set_fr(0, 8'h02, 8'($urandom), 8'($urandom), 8'($urandom));
                    send(1, 32);
                end
                4: begin
                    set_fr(0, 8'h03, 8'($urandom), 8'($urandom), 8'($urandom));
                    send(1, 32);
                end
                5: begin
                    set_fr(0, 8'h04, 8'($urandom), 8'($urandom), 8'($urandom));
                    send(1, 32);
                end
                6: begin
                    set_fr(0, 8'($urandom_range(5, 255)), 8'($urandom),
                           8'($urandom), 8'($urandom));
                    send(1, 32);
                end
                7: begin
                    set_fr(0, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom));
                    send(1, 32);
                end
                8: begin
                    set_fr(0, 8'($urandom_range(2, 4)), 8'($urandom),
                           8'($urandom), 8'($urandom));
                    set_fr(1, 8'($urandom_range(2, 4)), 8'($urandom),
                           8'($urandom), 8'($urandom));
                    send(2, 32);
                end
                default: begin
                    set_fr(0, 8'($urandom_range(2, 4)), 8'($urandom),
                           8'($urandom), 8'($urandom));
                    send(1, int'($urandom_range(1, 31)));
                end
            endcase
        end

        // Reset in the middle of a READ frame with words queued.
        set_fr(0, 8'h01, 8'h00, 8'h00, 8'h00);
        send(1, 32);
        set_fr(0, 8'h03, 8'h5A, 8'h00, 8'h00);
        send(1, 32);
        push_w(16'h1234);
        push_w(16'h5678);
        @(negedge clk);
        spi_ss = 1'b0;
        #100;
        for (int i = 0; i < 10; i++) begin
            spi_mosi = (i == 1);
            #50 spi_sck = 1'b1;
            #50 spi_sck = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        rst_n = 1'b1;
        spi_ss = 1'b1;
        init_m = 1'b0;
        udf_m  = 1'b0;
        ovf_m  = 1'b0;
        fq.delete();
        #200;
        set_fr(0, 8'h03, 8'h77, 8'h00, 8'h00);
        send(1, 32);
        set_fr(0, 8'h01, 8'h00, 8'h00, 8'h00);
        send(1, 32);
        set_fr(0, 8'h00, 8'h00, 8'h00, 8'h00);
        send(1, 32);

        #1000;
        chk("miso_pending", exp_miso.size(), 0);
        chk("cmd_pending", exp_cmd.size(), 0);
        chk("data_pending", exp_dat.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
